// File: rtl/apb_spi_master_periph.sv
// APB slave wrapping a mode-0, MSB-first, 8-bit SPI master with TX/RX FIFOs.
// Chip-select stays low across bytes while the TX FIFO keeps supplying data.
module apb_spi_master_periph #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 8
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [3:0]  PADDR,
    input  logic [31:0] PWDATA,
    input  logic        PWRITE,
    input  logic        PENABLE,
    input  logic        PSEL,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic        cs_n
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   PTR_ONE = 1;
    localparam logic [DIV_W-1:0] DIV_ONE = 1;
    localparam logic [3:0] ADDR_CR  = 4'h0;
    localparam logic [3:0] ADDR_SR  = 4'h4;
    localparam logic [3:0] ADDR_TXD = 4'h8;
    localparam logic [3:0] ADDR_RXD = 4'hC;

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP} state_t;

    logic             pready;
    logic             access;
    logic             wr_access;
    logic             rd_access;
    logic [31:0]      rdata;
    logic             cr_en;
    logic [DIV_W-1:0] cr_div;
    logic             rx_ovf;
    logic             tx_drop;

    logic [7:0]       tx_mem [FIFO_DEPTH];
    logic [PTR_W:0]   tx_wr;
    logic [PTR_W:0]   tx_rd;
    logic             tx_empty;
    logic             tx_full;
    logic             tx_push;

    logic [7:0]       rx_mem [FIFO_DEPTH];
    logic [PTR_W:0]   rx_wr;
    logic [PTR_W:0]   rx_rd;
    logic             rx_empty;
    logic             rx_full;
    logic             rx_push;
    logic             rx_pop;

    state_t           state;
    state_t           next_state;
    logic [DIV_W-1:0] div_cnt;
    logic             div_zero;
    logic [3:0]       bit_cnt;
    logic [7:0]       tx_sr;
    logic [7:0]       rx_sr;
    logic             start;
    logic             sample;
    logic             shift;
    logic             rx_push_req;
    logic             busy;
    logic             unused_bits;

    assign unused_bits = ^PWDATA[31:8+DIV_W];

    // The wait state makes every access two cycles; side effects happen on the second.
    assign access    = PSEL & PENABLE & pready;
    assign wr_access = access & PWRITE;
    assign rd_access = access & ~PWRITE;
    assign PREADY    = pready;
    assign PRDATA    = pready ? rdata : '0;

    assign tx_empty = (tx_wr == tx_rd);
    assign tx_full  = (tx_wr[PTR_W] != tx_rd[PTR_W]) &&
                      (tx_wr[PTR_W-1:0] == tx_rd[PTR_W-1:0]);
    assign rx_empty = (rx_wr == rx_rd);
    assign rx_full  = (rx_wr[PTR_W] != rx_rd[PTR_W]) &&
                      (rx_wr[PTR_W-1:0] == rx_rd[PTR_W-1:0]);

    assign tx_push  = wr_access && (PADDR == ADDR_TXD) && !tx_full;
    assign rx_pop   = rd_access && (PADDR == ADDR_RXD) && !rx_empty;
    assign rx_push  = rx_push_req && !rx_full;
    assign div_zero = (div_cnt == '0);
    assign mosi     = tx_sr[7];

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            pready  <= 1'b0;
            cr_en   <= 1'b0;
            cr_div  <= '0;
            rx_ovf  <= 1'b0;
            tx_drop <= 1'b0;
        end else begin
            pready <= PSEL & PENABLE & ~pready;
            if (wr_access && PADDR == ADDR_CR) begin
                cr_en  <= PWDATA[0];
                cr_div <= PWDATA[8 +: DIV_W];
            end
            if (wr_access && PADDR == ADDR_SR && PWDATA[4])
                tx_drop <= 1'b0;
            if (wr_access && PADDR == ADDR_TXD && tx_full)
                tx_drop <= 1'b1;
            if (wr_access && PADDR == ADDR_SR && PWDATA[3])
                rx_ovf <= 1'b0;
            if (rx_push_req && rx_full)
                rx_ovf <= 1'b1;
        end
    end

    always_comb begin
        rdata = '0;
        case (PADDR)
            ADDR_CR:  rdata = {{(24-DIV_W){1'b0}}, cr_div, 7'b0, cr_en};
            ADDR_SR:  rdata = {27'b0, tx_drop, rx_ovf, rx_empty, tx_full, busy};
            ADDR_RXD: if (!rx_empty) rdata = {24'b0, rx_mem[rx_rd[PTR_W-1:0]]};
            default:  rdata = '0;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            tx_wr <= '0;
            tx_rd <= '0;
            rx_wr <= '0;
            rx_rd <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + PTR_ONE;
            if (start)   tx_rd <= tx_rd + PTR_ONE;
            if (rx_push) rx_wr <= rx_wr + PTR_ONE;
            if (rx_pop)  rx_rd <= rx_rd + PTR_ONE;
        end
    end

    always_ff @(posedge PCLK) begin
        if (tx_push) tx_mem[tx_wr[PTR_W-1:0]] <= PWDATA[7:0];
        if (rx_push) rx_mem[rx_wr[PTR_W-1:0]] <= rx_sr;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (cr_en && !tx_empty) next_state = SETUP;
            SETUP:   if (div_zero) next_state = HIGH;
            HIGH:    if (div_zero) next_state = LOW;
            LOW:     if (div_zero) next_state = (bit_cnt == 4'd8) ? GAP : HIGH;
            GAP:     next_state = (cr_en && !tx_empty) ? SETUP : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        start       = 1'b0;
        sample      = 1'b0;
        shift       = 1'b0;
        rx_push_req = 1'b0;
        sclk        = (state == HIGH);
        cs_n        = (state == IDLE);
        busy        = (state != IDLE);
        case (state)
            IDLE:  start = cr_en && !tx_empty;
            SETUP: sample = div_zero;
            HIGH:  shift = div_zero;
            LOW:   sample = div_zero && (bit_cnt != 4'd8);
            GAP: begin
                rx_push_req = 1'b1;
                start       = cr_en && !tx_empty;
            end
            default: ;
        endcase
    end

    // Divider reloads on every half-period boundary, so a new CLKDIV lands there.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
        end else begin
            if (state == IDLE || state == GAP || div_zero)
                div_cnt <= cr_div;
            else
                div_cnt <= div_cnt - DIV_ONE;
            if (start) begin
                tx_sr   <= tx_mem[tx_rd[PTR_W-1:0]];
                bit_cnt <= '0;
            end else if (shift) begin
                tx_sr <= {tx_sr[6:0], 1'b0};
            end
            if (sample)
                bit_cnt <= bit_cnt + 4'd1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (sample) rx_sr <= {rx_sr[6:0], miso};
    end

endmodule

// File: tb/tb_apb_spi_master_periph.sv
// Directed bench for apb_spi_master_periph: reads queue their expected data,
// a monitor compares on PREADY; a frame monitor measures SPI waveforms.
module tb_apb_spi_master_periph;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic [3:0]  PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic        PWRITE = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PSEL = 1'b0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic        cs_n;

    assign miso = mosi;

    apb_spi_master_periph #(.FIFO_DEPTH(4), .DIV_W(8)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWDATA(PWDATA),
        .PWRITE(PWRITE), .PENABLE(PENABLE), .PSEL(PSEL), .PRDATA(PRDATA),
        .PREADY(PREADY), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
    );

    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Read-data monitor: pops one expectation per completed read.
    always @(negedge PCLK) begin
        if (PSEL && PENABLE && PREADY && !PWRITE) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_read: got 0x%08h with no expectation queued", PRDATA);
            end else begin
                mon_e = exp_q.pop_front();
                chk(mon_e.name, PRDATA, mon_e.exp);
            end
        end
    end

    // Frame monitor: cs_n low length, sclk pulses, mosi bits, sclk high widths.
    logic        cs_prev = 1'b1;
    logic        sclk_prev = 1'b0;
    int          run = 0, pulses = 0, hrun = 0, hmin = 0, hmax = 0;
    int          last_run = 0, last_pulses = 0, last_hmin = 0, last_hmax = 0;
    int          frames = 0;
    logic [31:0] mosi_bits = '0;
    logic [31:0] last_mosi = '0;

    always @(negedge PCLK) begin
        if (!cs_n && cs_prev) begin
            run = 0; pulses = 0; mosi_bits = '0; hmin = 1000; hmax = 0; hrun = 0;
        end
        if (!cs_n) begin
            run++;
            if (sclk && !sclk_prev) begin
                pulses++;
                mosi_bits = {mosi_bits[30:0], mosi};
            end
            if (sclk) hrun++;
            else if (sclk_prev) begin
                if (hrun < hmin) hmin = hrun;
                if (hrun > hmax) hmax = hrun;
                hrun = 0;
            end
        end
        if (cs_n && !cs_prev) begin
            last_run = run; last_pulses = pulses; last_mosi = mosi_bits;
            last_hmin = hmin; last_hmax = hmax;
            frames++;
        end
        cs_prev = cs_n;
        sclk_prev = sclk;
    end

    task automatic apb(input logic wr, input logic [3:0] a, input logic [31:0] d);
        int n;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        n = 0;
        while (n < 16) begin
            @(negedge PCLK);
            if (PREADY) break;
            n++;
        end
        chk("pready_wait_cycles", n, 1);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        apb(1'b1, a, d);
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string name);
        exp_t e;
        e.name = name;
        e.exp = exp;
        exp_q.push_back(e);
        apb(1'b0, a, 32'h0);
    endtask

    task automatic wait_frames(input int target, input string name);
        int n = 0;
        while (frames < target && n < 5000) begin
            @(negedge PCLK);
            n++;
        end
        chk(name, frames, target);
    endtask

    task automatic wait_quiet(input string name);
        int n = 0;
        int quiet = 0;
        while (quiet < 30 && n < 5000) begin
            @(negedge PCLK);
            n++;
            if (cs_n) quiet++;
            else quiet = 0;
        end
        chk(name, (quiet >= 30), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        int n;

        // Power-on reset state
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        chk("rst_prdata", PRDATA, 32'h0);
        chk("rst_pready", PREADY, 1'b0);
        chk("rst_sclk", sclk, 1'b0);
        chk("rst_mosi", mosi, 1'b0);
        chk("rst_cs_n", cs_n, 1'b1);
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        rd(4'h4, 32'h4, "rst_sr");
        rd(4'h0, 32'h0, "rst_cr");

        // APB timing and CR readback
        wr(4'h0, 32'h0000_0001);
        rd(4'h0, 32'h0000_0001, "cr_readback");
        @(negedge PCLK);
        chk("pready_drops_after", PREADY, 1'b0);
        rd(4'h1, 32'h0, "undef_addr_read");
        rd(4'h8, 32'h0, "txd_read_zero");

        // Single byte, CLKDIV=0
        f0 = frames;
        wr(4'h8, 32'hA5);
        wait_frames(f0 + 1, "single_frame_done");
        chk("single_pulses", last_pulses, 8);
        chk("single_mosi", last_mosi, 32'h0000_00A5);
        chk("single_cs_low", last_run, 18);
        chk("single_sclk_high", last_hmax, 1);
        rd(4'hC, 32'hA5, "single_rxd");
        rd(4'h4, 32'h4, "single_sr_after");

        // Back-to-back bytes, CLKDIV=3
        wr(4'h0, 32'h0000_0301);
        f0 = frames;
        wr(4'h8, 32'h11);
        wr(4'h8, 32'h22);
        wr(4'h8, 32'h33);
        wait_frames(f0 + 1, "b2b_frame_done");
        chk("b2b_pulses", last_pulses, 24);
        chk("b2b_mosi", last_mosi, 32'h0011_2233);
        chk("b2b_cs_low", last_run, 207);
        chk("b2b_sclk_high_min", last_hmin, 4);
        chk("b2b_sclk_high_max", last_hmax, 4);
        rd(4'hC, 32'h11, "b2b_rxd0");
        rd(4'hC, 32'h22, "b2b_rxd1");
        rd(4'hC, 32'h33, "b2b_rxd2");
        rd(4'h4, 32'h4, "b2b_sr_after");

        // TX overflow with EN=0
        wr(4'h0, 32'h0);
        for (int i = 1; i <= 5; i++) wr(4'h8, i);
        rd(4'h4, 32'h16, "txovf_sr");
        f0 = frames;
        wr(4'h0, 32'h1);
        wait_frames(f0 + 1, "txovf_frame_done");
        chk("txovf_pulses", last_pulses, 32);
        chk("txovf_cs_low", last_run, 72);
        chk("txovf_mosi", last_mosi, 32'h0102_0304);
        rd(4'hC, 32'h01, "txovf_rxd0");
        rd(4'hC, 32'h02, "txovf_rxd1");
        rd(4'hC, 32'h03, "txovf_rxd2");
        rd(4'hC, 32'h04, "txovf_rxd3");
        rd(4'hC, 32'h00, "txovf_rxd_empty");
        rd(4'h4, 32'h14, "txovf_sr_drop_kept");
        wr(4'h4, 32'h10);
        rd(4'h4, 32'h04, "txovf_sr_cleared");

        // RX overflow and empty read
        wr(4'h8, 32'h5A);
        wr(4'h8, 32'hC3);
        wr(4'h8, 32'h3C);
        wr(4'h8, 32'h96);
        wr(4'h8, 32'h81);
        wait_quiet("rxovf_quiet");
        rd(4'h4, 32'h08, "rxovf_sr");
        rd(4'hC, 32'h5A, "rxovf_rxd0");
        rd(4'hC, 32'hC3, "rxovf_rxd1");
        rd(4'hC, 32'h3C, "rxovf_rxd2");
        rd(4'hC, 32'h96, "rxovf_rxd3");
        rd(4'hC, 32'h00, "rxovf_rxd_empty");
        rd(4'h4, 32'h0C, "rxovf_sr_empty");
        wr(4'h4, 32'h08);
        rd(4'h4, 32'h04, "rxovf_sr_cleared");

        // Reset during HIGH
        wr(4'h0, 32'h0000_0301);
        wr(4'h8, 32'h77);
        n = 0;
        while (!sclk && n < 200) begin
            @(negedge PCLK);
            n++;
        end
        chk("midrst_in_high", sclk, 1'b1);
        chk("midrst_cs_low", cs_n, 1'b0);
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        @(negedge PCLK);
        chk("midrst_cs_n", cs_n, 1'b1);
        chk("midrst_sclk", sclk, 1'b0);
        chk("midrst_mosi", mosi, 1'b0);
        rd(4'h4, 32'h4, "midrst_sr");
        rd(4'hC, 32'h0, "midrst_rxd");
        rd(4'h0, 32'h0, "midrst_cr");

        repeat (4) @(posedge PCLK);
        chk("expect_queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_spi_master_periph.md
Name: apb_spi_master_periph

Overview:
- APB slave peripheral, downstream of the MCU's APB master; occupies one free PSEL slot on the bus.
- Gives firmware an SPI master in mode 0 (CPOL=0, CPHA=0), 8-bit frames, MSB first.
- 4-entry TX FIFO and 4-entry RX FIFO let the core queue bytes without polling every bit.
- Chip-select is held low across back-to-back bytes while the TX FIFO stays non-empty.

Parameters:
FIFO_DEPTH, 4, entries in each of the TX and RX FIFOs (power of 2).
DIV_W, 8, width of the SCLK divider field.

Ports:
PCLK  input  1  system clock; the only clock.
PRESET  input  1  synchronous, active-high reset.
PADDR  input  4  register byte address.
PWDATA  input  32  write data.
PWRITE  input  1  1=write, 0=read.
PENABLE  input  1  APB access phase.
PSEL  input  1  slave select.
PRDATA  output  32  read data.
PREADY  output  1  transfer complete.
sclk  output  1  SPI clock.
mosi  output  1  SPI data out.
miso  input  1  SPI data in.
cs_n  output  1  SPI chip select, active low.

Behaviour:
- Reset values (all outputs): PRDATA=0, PREADY=0, sclk=0, mosi=0, cs_n=1. Reset also empties both FIFOs, sets CR=0, clears all sticky flags and returns the FSM to IDLE.
- Reset is synchronous and takes effect immediately, including mid-frame.
- APB handshake:
  - The first cycle with PSEL&PENABLE drives PREADY=0.
  - The next cycle drives PREADY=1 for exactly one cycle, with PRDATA valid.
  - Register side effects (push, pop, flag clear) occur only in the PREADY=1 cycle.
  - PREADY returns to 0 afterwards.
- Register map:
  - 0x0 CR (RW): bit0 EN; bits[8+DIV_W-1:8] CLKDIV.
  - 0x4 SR:
    - bit0 BUSY (RO).
    - bit1 TX_FULL (RO).
    - bit2 RX_EMPTY (RO).
    - bit3 RX_OVF (sticky, write-1-to-clear).
    - bit4 TX_DROP (sticky, write-1-to-clear).
  - 0x8 TXD (WO): PWDATA[7:0] is pushed to the TX FIFO. Reads return 0.
  - 0xC RXD (RO): reads pop the RX FIFO and return the byte in [7:0]. Writes are ignored.
  - Undefined addresses read 0; writes to them are ignored.
- TXD write while the TX FIFO is full: data is dropped and TX_DROP is set.
- RXD read while the RX FIFO is empty: returns 0, no pop, no flag.
- An APB push and an engine pop on the same TX FIFO cycle both take effect; the count is unchanged.
- SCLK half-period is CLKDIV+1 PCLK cycles, counted by a divider counter.
- FSM states: IDLE, SETUP, HIGH, LOW, GAP.
  - IDLE → SETUP when EN=1 and the TX FIFO is non-empty. On this transition: pop a byte into the shift register, drive cs_n=0, drive mosi=bit7.
  - SETUP (sclk=0) waits one half-period, then → HIGH.
  - HIGH (sclk=1): at entry, sample miso into the RX shift register LSB. After one half-period, → LOW.
  - LOW (sclk=0): at entry, shift mosi to the next bit. After one half-period, → HIGH if fewer than 8 bits have been sampled, otherwise → GAP.
  - GAP: push the RX byte. If the RX FIFO is full, discard the byte and set RX_OVF.
  - GAP with EN=1 and TX non-empty: pop the next byte and → SETUP with cs_n held 0.
  - GAP otherwise: drive cs_n=1 and → IDLE.
- BUSY = (state ≠ IDLE).
- Clearing EN mid-frame: the current byte completes, then the FSM goes to IDLE with cs_n=1. Queued TX bytes remain.
- CLKDIV changes take effect at the next half-period reload.
- One-byte frame length, from pop to cs_n=1: 17×(CLKDIV+1)+1 PCLK cycles.

Test Plan:
- Reset mid-frame:
  - Stimulus: assert PRESET during HIGH.
  - Required response: next cycle cs_n=1, sclk=0, mosi=0, SR=0x4, and an RXD read returns 0.
- APB timing:
  - Stimulus: write CR=0x0001, then read CR.
  - Required response: PREADY low for the first access cycle and high for the second; read returns 0x00000001.
- Single byte:
  - Stimulus: CLKDIV=0, miso looped to mosi, write TXD=0xA5.
  - Required response: 8 sclk pulses; mosi sequence 1,0,1,0,0,1,0,1; cs_n low for 18 cycles; RXD read = 0xA5; SR=0x4 afterwards.
- Back-to-back bytes:
  - Stimulus: CLKDIV=3, write 0x11, 0x22, 0x33.
  - Required response: cs_n stays low through all 24 bits; sclk half-period = 4 cycles; RX FIFO returns 0x11, 0x22, 0x33 in order.
- TX overflow:
  - Stimulus: EN=0, write 5 bytes.
  - Required response: SR.TX_FULL=1 and TX_DROP=1. After EN=1, exactly 4 bytes are transmitted. Writing SR=0x10 clears TX_DROP.
- RX overflow / empty read:
  - Stimulus: send 5 bytes without reading RXD.
  - Required response: RX_OVF=1 and the first 4 bytes are retained. After 4 reads, a 5th read returns 0 and RX_EMPTY=1.
